// File: rtl/db9md_pkg.sv
// Shared types and constants for the dual Mega Drive pad scanner on a split DB9 port.
package db9md_pkg;

   typedef enum logic [1:0] {
      PAD_NONE = 2'd0,
      PAD_3BTN = 2'd1,
      PAD_6BTN = 2'd2
   } pad_type_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SEQ,
      ST_COMMIT
   } scan_state_e;

   // Bit positions in the published active-high button word
   localparam int BTN_R     = 0;
   localparam int BTN_L     = 1;
   localparam int BTN_D     = 2;
   localparam int BTN_U     = 3;
   localparam int BTN_B     = 4;
   localparam int BTN_C     = 5;
   localparam int BTN_A     = 6;
   localparam int BTN_START = 7;
   localparam int BTN_MODE  = 8;
   localparam int BTN_X     = 9;
   localparam int BTN_Y     = 10;
   localparam int BTN_Z     = 11;

   localparam logic [2:0] PH_DPAD    = 3'd0;
   localparam logic [2:0] PH_PRESENT = 3'd1;
   localparam logic [2:0] PH_SIX     = 3'd5;
   localparam logic [2:0] PH_XYZ     = 3'd6;
   localparam logic [2:0] PH_LAST    = 3'd7;

endpackage

// File: rtl/db9md_pad_decode.sv
// Per-phase capture of the currently routed pad; presents a decoded word and pad type.
module db9md_pad_decode
   import db9md_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear_i,
   input  logic        sample_i,
   input  logic [2:0]  phase_i,
   input  logic [5:0]  pins_i,
   output logic [15:0] word_o,
   output logic [1:0]  type_o
);

   logic [11:0] btn_q, btn_d;
   logic        present_q, present_d;
   logic        six_q, six_d;
   logic [5:0]  pressed;

   assign pressed = ~pins_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_q     <= '0;
         present_q <= 1'b0;
         six_q     <= 1'b0;
      end else begin
         btn_q     <= btn_d;
         present_q <= present_d;
         six_q     <= six_d;
      end
   end

   // Pin meaning depends on the select phase; XYZ/Mode only exist once a six-button id was seen
   always_comb begin
      btn_d     = btn_q;
      present_d = present_q;
      six_d     = six_q;
      if (clear_i) begin
         btn_d     = '0;
         present_d = 1'b0;
         six_d     = 1'b0;
      end else if (sample_i) begin
         case (phase_i)
            PH_DPAD: begin
               btn_d[BTN_U] = pressed[0];
               btn_d[BTN_D] = pressed[1];
               btn_d[BTN_L] = pressed[2];
               btn_d[BTN_R] = pressed[3];
               btn_d[BTN_B] = pressed[4];
               btn_d[BTN_C] = pressed[5];
            end
            PH_PRESENT: begin
               btn_d[BTN_A]     = pressed[4];
               btn_d[BTN_START] = pressed[5];
               present_d        = (pins_i[3:2] == 2'b00);
            end
            PH_SIX: six_d = (pins_i[3:0] == 4'b0000);
            PH_XYZ: begin
               if (six_q) begin
                  btn_d[BTN_Z]    = pressed[0];
                  btn_d[BTN_Y]    = pressed[1];
                  btn_d[BTN_X]    = pressed[2];
                  btn_d[BTN_MODE] = pressed[3];
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      word_o = '0;
      type_o = PAD_NONE;
      if (present_q) begin
         word_o[11:0] = btn_q;
         if (six_q) begin
            type_o = PAD_6BTN;
         end else begin
            type_o       = PAD_3BTN;
            word_o[11:8] = 4'h0;
         end
      end
   end

endmodule

// File: rtl/db9md_pad_scanner.sv
// Scans two Mega Drive pads through one DB9 port using the split line; registered outputs change only at commit.
// Optional per-bit two-scan agreement filter on the words when DB9MD_DEBOUNCE_EN is defined.
module db9md_pad_scanner
   import db9md_pkg::*;
#(
   parameter int PHASE_CYCLES = 480,
   parameter int SCAN_CYCLES  = 96000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [5:0]  joy_in,
   output logic        joy_mdsel,
   output logic        joy_split,
   output logic [15:0] joystick1,
   output logic [15:0] joystick2,
   output logic [1:0]  pad1_type,
   output logic [1:0]  pad2_type
);

   localparam int PW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
   localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam logic [PW-1:0] PHASE_END = PW'(PHASE_CYCLES - 1);
   localparam logic [SW-1:0] SCAN_END  = SW'(SCAN_CYCLES - 1);

   scan_state_e   state_q, state_d;
   logic [PW-1:0] phaseCnt_q, phaseCnt_d;
   logic [SW-1:0] scanCnt_q;
   logic [2:0]    phase_q, phase_d;
   logic          split_q, split_d;
   logic          mdsel_q, mdsel_d;
   logic [5:0]    sync1_q, sync2_q;
   logic [15:0]   joy1_q, joy2_q, newWord, decWord;
   logic [1:0]    type1_q, type2_q, decType;
   logic          phaseEnd, scanWrap, commit;

   assign phaseEnd = (phaseCnt_q == PHASE_END);
   assign scanWrap = (scanCnt_q == SCAN_END);
   assign commit   = (state_q == ST_COMMIT);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         phaseCnt_q <= '0;
         scanCnt_q  <= '0;
         phase_q    <= '0;
         split_q    <= 1'b0;
         mdsel_q    <= 1'b1;
         sync1_q    <= '1;
         sync2_q    <= '1;
      end else begin
         state_q    <= state_d;
         phaseCnt_q <= phaseCnt_d;
         scanCnt_q  <= scanWrap ? '0 : scanCnt_q + 1'b1;
         phase_q    <= phase_d;
         split_q    <= split_d;
         mdsel_q    <= mdsel_d;
         sync1_q    <= joy_in;
         sync2_q    <= sync1_q;
      end
   end

   // Select is registered from the next state so the pad sees a clean edge at each phase start
   always_comb begin
      state_d    = state_q;
      phaseCnt_d = phaseCnt_q;
      phase_d    = phase_q;
      split_d    = split_q;
      case (state_q)
         ST_IDLE: begin
            phaseCnt_d = '0;
            if (scanWrap) begin
               state_d = ST_SETTLE;
               split_d = 1'b0;
            end
         end
         ST_SETTLE: begin
            phaseCnt_d = phaseEnd ? '0 : phaseCnt_q + 1'b1;
            if (phaseEnd) begin
               state_d = ST_SEQ;
               phase_d = PH_DPAD;
            end
         end
         ST_SEQ: begin
            phaseCnt_d = phaseEnd ? '0 : phaseCnt_q + 1'b1;
            if (phaseEnd) begin
               if (phase_q == PH_LAST) state_d = ST_COMMIT;
               else                    phase_d = phase_q + 3'd1;
            end
         end
         ST_COMMIT: begin
            phaseCnt_d = '0;
            split_d    = ~split_q;
            state_d    = split_q ? ST_IDLE : ST_SETTLE;
         end
         default: state_d = ST_IDLE;
      endcase
      mdsel_d = !((state_d == ST_SEQ) && phase_d[0]);
   end

   db9md_pad_decode u_decode (
      .clk      (clk_sys),
      .rst_n    (reset_n),
      .clear_i  (state_q == ST_SETTLE),
      .sample_i ((state_q == ST_SEQ) && phaseEnd),
      .phase_i  (phase_q),
      .pins_i   (sync2_q),
      .word_o   (decWord),
      .type_o   (decType)
   );

`ifdef DB9MD_DEBOUNCE_EN
   logic [15:0] prev1_q, prev2_q, curPrev, curOut, disagree;

   // A bit moves only when this scan agrees with the previous raw scan of the same pad
   always_comb begin
      curPrev  = split_q ? prev2_q : prev1_q;
      curOut   = split_q ? joy2_q : joy1_q;
      disagree = decWord ^ curPrev;
      newWord  = (decWord & ~disagree) | (curOut & disagree);
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         prev1_q <= '0;
         prev2_q <= '0;
      end else if (commit) begin
         if (split_q) prev2_q <= decWord;
         else         prev1_q <= decWord;
      end
   end
`else
   assign newWord = decWord;
`endif

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         joy1_q  <= '0;
         joy2_q  <= '0;
         type1_q <= PAD_NONE;
         type2_q <= PAD_NONE;
      end else if (commit) begin
         if (split_q) begin
            joy2_q  <= newWord;
            type2_q <= decType;
         end else begin
            joy1_q  <= newWord;
            type1_q <= decType;
         end
      end
   end

   assign joy_mdsel = mdsel_q;
   assign joy_split = split_q;
   assign joystick1 = joy1_q;
   assign joystick2 = joy2_q;
   assign pad1_type = type1_q;
   assign pad2_type = type2_q;

endmodule

// File: tb/tb_db9md_pad_scanner.sv
// Scoreboard bench for db9md_pad_scanner with a behavioural pair of Mega Drive pads behind the split line.
module tb_db9md_pad_scanner;
   import db9md_pkg::*;

   localparam int PH      = 8;
   localparam int SC      = 400;
   localparam int TIMEOUT = 300;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic [5:0]  joy_in;
   logic        joy_mdsel, joy_split;
   logic [15:0] joystick1, joystick2;
   logic [1:0]  pad1_type, pad2_type;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   int scanIdx    = 1;

   typedef struct {
      int          pad;
      logic [15:0] word;
      logic [1:0]  ptype;
      int          atCyc;
   } exp_t;
   exp_t expQ[$];

   bit          padPlug[2]  = '{1'b0, 1'b0};
   bit          padSix[2]   = '{1'b0, 1'b0};
   logic [11:0] padBtn[2]   = '{12'h0, 12'h0};
   int          padEdges[2] = '{0, 0};
   int          padIdle[2]  = '{0, 0};
   logic        padSel[2]   = '{1'b1, 1'b1};
   logic        seenSel[2];
   logic [15:0] dbPrev[2]   = '{16'h0, 16'h0};
   logic [15:0] dbOut[2]    = '{16'h0, 16'h0};

   db9md_pad_scanner #(.PHASE_CYCLES(PH), .SCAN_CYCLES(SC)) dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .joy_in    (joy_in),
      .joy_mdsel (joy_mdsel),
      .joy_split (joy_split),
      .joystick1 (joystick1),
      .joystick2 (joystick2),
      .pad1_type (pad1_type),
      .pad2_type (pad2_type)
   );

   always #5 clk_sys = ~clk_sys;

   // Only the routed pad sees select; the other one sits with TH high
   always_comb begin
      seenSel[0] = joy_split ? 1'b1 : joy_mdsel;
      seenSel[1] = joy_split ? joy_mdsel : 1'b1;
   end

   // Pad answer: 6-button pads count TH falling edges; third low phase ids, fourth high gives XYZ/Mode
   always_comb begin
      int          p;
      logic [11:0] b;
      logic [5:0]  pr;
      p  = joy_split ? 1 : 0;
      b  = padBtn[p];
      pr = '0;
      if (joy_mdsel) begin
         if (padSix[p] && padEdges[p] == 3)
            pr = {b[BTN_C], b[BTN_B], b[BTN_MODE], b[BTN_X], b[BTN_Y], b[BTN_Z]};
         else
            pr = {b[BTN_C], b[BTN_B], b[BTN_R], b[BTN_L], b[BTN_D], b[BTN_U]};
      end else begin
         if (padSix[p] && padEdges[p] == 3)
            pr = {b[BTN_START], b[BTN_A], 4'hF};
         else if (padSix[p] && padEdges[p] == 4)
            pr = {b[BTN_START], b[BTN_A], 4'h0};
         else
            pr = {b[BTN_START], b[BTN_A], 2'b11, b[BTN_D], b[BTN_U]};
      end
      joy_in = padPlug[p] ? ~pr : 6'h3F;
   end

   initial forever begin
      @(negedge clk_sys);
      for (int p = 0; p < 2; p++) begin
         if (seenSel[p] != padSel[p]) begin
            padIdle[p] = 0;
            if (!seenSel[p]) padEdges[p] = padEdges[p] + 1;
         end else if (padIdle[p] < TIMEOUT) begin
            padIdle[p] = padIdle[p] + 1;
         end else begin
            padEdges[p] = 0;
         end
         padSel[p] = seenSel[p];
      end
   end

   initial forever begin
      @(posedge clk_sys);
      cyc = reset_n ? cyc + 1 : 0;
   end

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_mdsel"}, 16'(joy_mdsel), 16'h1);
      checkOutput({tag, "_split"}, 16'(joy_split), 16'h0);
      checkOutput({tag, "_joy1"},  joystick1, 16'h0);
      checkOutput({tag, "_joy2"},  joystick2, 16'h0);
      checkOutput({tag, "_type1"}, 16'(pad1_type), 16'h0);
      checkOutput({tag, "_type2"}, 16'(pad2_type), 16'h0);
   endtask

   task automatic applyStimulus(input bit p1Plug, input bit p1Six, input logic [11:0] p1Btn,
                                input bit p2Plug, input bit p2Six, input logic [11:0] p2Btn);
      padPlug[0] = p1Plug; padSix[0] = p1Six; padBtn[0] = p1Btn;
      padPlug[1] = p2Plug; padSix[1] = p2Six; padBtn[1] = p2Btn;
   endtask

   function automatic logic [15:0] filterWord(input int p, input logic [15:0] raw);
`ifdef DB9MD_DEBOUNCE_EN
      logic [15:0] dis;
      dis       = raw ^ dbPrev[p];
      dbOut[p]  = (raw & ~dis) | (dbOut[p] & dis);
      dbPrev[p] = raw;
      return dbOut[p];
`else
      return raw + 16'h0 * 16'(p);
`endif
   endfunction

   // Expected raw decode for the next scan pair; commit cycles follow from the fixed scan schedule
   task automatic pushScan(input logic [15:0] w1, input logic [1:0] t1,
                           input logic [15:0] w2, input logic [1:0] t2);
      exp_t e;
      e.pad = 1; e.word = filterWord(0, w1); e.ptype = t1; e.atCyc = SC * scanIdx + 9 * PH + 1;
      expQ.push_back(e);
      e.pad = 2; e.word = filterWord(1, w2); e.ptype = t2; e.atCyc = SC * scanIdx + 18 * PH + 2;
      expQ.push_back(e);
      scanIdx++;
   endtask

   task automatic drainScan();
      int n = 0;
      while (expQ.size() != 0 && n < 3 * SC) begin
         @(negedge clk_sys);
         n++;
      end
      if (expQ.size() != 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL scan_timeout: %0d commits pending, required 0", expQ.size());
         expQ.delete();
      end
   endtask

   task automatic waitCycle(input int target);
      int n = 0;
      while (cyc < target && n < 3 * SC) begin
         @(negedge clk_sys);
         n++;
      end
      if (cyc < target) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL wait_cycle: reached %0d, required %0d", cyc, target);
      end
   endtask

   // Monitor: a split toggle marks a commit; any other output change is an illegal partial update
   initial begin
      logic        prevSplit = 1'b0;
      logic        prevRstOk = 1'b0;
      logic [15:0] prevJ1 = '0, prevJ2 = '0;
      logic [1:0]  prevT1 = '0, prevT2 = '0;
      exp_t        e;
      forever begin
         @(negedge clk_sys);
         if (reset_n && prevRstOk) begin
            if (joy_split != prevSplit) begin
               if (expQ.size() == 0) begin
                  compared++;
                  mismatched++;
                  $display("[TB] FAIL unexpected_commit: pad %0d at cycle %0d, required none",
                           prevSplit ? 2 : 1, cyc);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("commit_pad", 16'(prevSplit ? 2 : 1), 16'(e.pad));
                  checkOutput("commit_cycle", 16'(cyc), 16'(e.atCyc));
                  checkOutput("commit_word", prevSplit ? joystick2 : joystick1, e.word);
                  checkOutput("commit_type", 16'(prevSplit ? pad2_type : pad1_type), 16'(e.ptype));
               end
            end else if (joystick1 !== prevJ1 || joystick2 !== prevJ2 ||
                         pad1_type !== prevT1 || pad2_type !== prevT2) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL hold_outputs: changed to %h/%h/%0d/%0d at cycle %0d, required no change",
                        joystick1, joystick2, pad1_type, pad2_type, cyc);
            end
         end
         prevSplit = joy_split;
         prevRstOk = reset_n;
         prevJ1 = joystick1; prevJ2 = joystick2;
         prevT1 = pad1_type; prevT2 = pad2_type;
      end
   end

   initial begin
      int tgt;
      applyStimulus(1'b1, 1'b1, 12'h848, 1'b0, 1'b0, 12'h000);
      repeat (5) @(negedge clk_sys);
      checkResetValues("reset_held");
      reset_n = 1'b1;

      $display("[TB] six-button pad 1 with A+Z+Up, pad 2 absent");
      pushScan(16'h0848, 2'd2, 16'h0000, 2'd0);
      drainScan();

      $display("[TB] three-button pad 2 with Start+Right, XYZ/Mode held in the model");
      applyStimulus(1'b1, 1'b1, 12'h848, 1'b1, 1'b0, 12'hF81);
      pushScan(16'h0848, 2'd2, 16'h0081, 2'd1);
      drainScan();

      $display("[TB] pad 1 unplugged between ph0 and ph1");
      tgt = SC * scanIdx + 2 * PH;
      pushScan(16'h0000, 2'd0, 16'h0081, 2'd1);
      waitCycle(tgt);
      applyStimulus(1'b0, 1'b1, 12'h848, 1'b1, 1'b0, 12'hF81);
      drainScan();

      applyStimulus(1'b1, 1'b1, 12'h848, 1'b1, 1'b0, 12'hF81);
      pushScan(16'h0848, 2'd2, 16'h0081, 2'd1);
      drainScan();

      $display("[TB] reset pulse during ph3");
      waitCycle(SC * scanIdx + 4 * PH + 2);
      #2 reset_n = 1'b0;
      #1 checkResetValues("reset_pulse");
      dbPrev = '{16'h0, 16'h0};
      dbOut  = '{16'h0, 16'h0};
      repeat (3) @(negedge clk_sys);
      reset_n = 1'b1;
      scanIdx = 1;
      pushScan(16'h0848, 2'd2, 16'h0081, 2'd1);
      drainScan();

      $display("[TB] B pressed for one scan, released, then held for two scans");
      applyStimulus(1'b1, 1'b1, 12'h858, 1'b1, 1'b0, 12'hF81);
      pushScan(16'h0858, 2'd2, 16'h0081, 2'd1);
      drainScan();
      applyStimulus(1'b1, 1'b1, 12'h848, 1'b1, 1'b0, 12'hF81);
      pushScan(16'h0848, 2'd2, 16'h0081, 2'd1);
      drainScan();
      applyStimulus(1'b1, 1'b1, 12'h858, 1'b1, 1'b0, 12'hF81);
      pushScan(16'h0858, 2'd2, 16'h0081, 2'd1);
      drainScan();
      pushScan(16'h0858, 2'd2, 16'h0081, 2'd1);
      drainScan();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
